// File: rtl/decode_pkg.sv
// Shared constants and FSM state type for the block decode/encode schedulers.
package decode_pkg;

   localparam int unsigned BLK_W       = 512;
   localparam int unsigned DEF_IDX_W   = 10;
   localparam int unsigned DEF_TIMEOUT = 256;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      CLEAR,
      RUN,
      EMIT,
      DONE,
      ABORT
   } sched_state_e;

   // Counter width able to hold 0..limit-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/decode_watchdog.sv
// Clearable up-counter bounding decoder run time; saturates and flags at TIMEOUT-1.
module decode_watchdog
   import decode_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned CNT_W   = cnt_width(TIMEOUT)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             tc_c_o
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Saturate at terminal count so a stuck run never wraps back to zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != TC_VAL)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_c_o  = (count_q == TC_VAL);

endmodule

// File: rtl/decode_block_scheduler.sv
// Sequences the 8x8 block decoder over a frame: fetch, clear, run, emit, repeat.
module decode_block_scheduler
   import decode_pkg::*;
#(
   parameter int unsigned IDX_W   = DEF_IDX_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [IDX_W-1:0] num_blocks_i,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic             error_o,
   input  logic             in_valid_i,
   input  logic [BLK_W-1:0] in_data_i,
   output logic             in_ready_o,
   output logic [BLK_W-1:0] dec_a_o,
   output logic             dec_reset_o,
   output logic             dec_enable_o,
   input  logic [BLK_W-1:0] dec_c_i,
   input  logic             dec_done_i,
   output logic             out_valid_o,
   output logic [BLK_W-1:0] out_data_o,
   output logic [IDX_W-1:0] out_index_o,
   input  logic             out_ready_i
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT);

   sched_state_e     state_q;
   logic [IDX_W-1:0] num_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q;
   logic             frame_done_q;
   logic             error_q;
   logic             in_ready_q;
   logic             dec_reset_q;
   logic             dec_enable_q;
   logic             out_valid_q;
   logic [BLK_W-1:0] dec_a_q;
   logic [BLK_W-1:0] out_data_q;
   logic [IDX_W-1:0] out_index_q;

   logic [CNT_W-1:0] wdog_cnt;
   logic             wdog_tc_c;
   logic             wdog_clear_c;
   logic             wdog_en_c;
   logic             last_blk_c;
   logic             done_seen_c;

   assign wdog_clear_c = (state_q == CLEAR);
   assign wdog_en_c    = (state_q == RUN);
   assign last_blk_c   = (idx_q == (num_q - IDX_W'(1)));
   // First RUN cycle (count still zero) masks a done left over from the previous block.
   assign done_seen_c  = dec_done_i && (wdog_cnt != '0);

   decode_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wdog (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (wdog_clear_c),
      .en_i    (wdog_en_c),
      .count_o (wdog_cnt),
      .tc_c_o  (wdog_tc_c)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         num_q        <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         error_q      <= 1'b0;
         in_ready_q   <= 1'b0;
         dec_reset_q  <= 1'b1;
         dec_enable_q <= 1'b0;
         out_valid_q  <= 1'b0;
         dec_a_q      <= '0;
         out_data_q   <= '0;
         out_index_q  <= '0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  num_q   <= num_blocks_i;
                  idx_q   <= '0;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
                  if (num_blocks_i == '0) begin
                     state_q <= DONE;
                  end else begin
                     state_q      <= FETCH;
                     in_ready_q   <= 1'b1;
                     dec_reset_q  <= 1'b0;
                     dec_enable_q <= 1'b0;
                  end
               end
            end
            FETCH: begin
               if (in_valid_i && in_ready_q) begin
                  dec_a_q     <= in_data_i;
                  in_ready_q  <= 1'b0;
                  dec_reset_q <= 1'b1;
                  state_q     <= CLEAR;
               end
            end
            CLEAR: begin
               dec_reset_q  <= 1'b0;
               dec_enable_q <= 1'b1;
               state_q      <= RUN;
            end
            RUN: begin
               if (done_seen_c) begin
                  out_data_q   <= dec_c_i;
                  out_index_q  <= idx_q;
                  out_valid_q  <= 1'b1;
                  dec_enable_q <= 1'b0;
                  state_q      <= EMIT;
               end else if (wdog_tc_c) begin
                  error_q      <= 1'b1;
                  dec_reset_q  <= 1'b1;
                  dec_enable_q <= 1'b0;
                  state_q      <= ABORT;
               end
            end
            EMIT: begin
               if (out_valid_q && out_ready_i) begin
                  out_valid_q <= 1'b0;
                  if (last_blk_c) begin
                     state_q <= DONE;
                  end else begin
                     idx_q      <= idx_q + IDX_W'(1);
                     in_ready_q <= 1'b1;
                     state_q    <= FETCH;
                  end
               end
            end
            DONE: begin
               frame_done_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
            ABORT: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign error_o      = error_q;
   assign in_ready_o   = in_ready_q;
   assign dec_a_o      = dec_a_q;
   assign dec_reset_o  = dec_reset_q;
   assign dec_enable_o = dec_enable_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_index_o  = out_index_q;

endmodule

// File: tb/tb_decode_block_scheduler.sv
// Directed bench for decode_block_scheduler with a behavioural RLE/zigzag decoder stub.
module tb_decode_block_scheduler;

   localparam int TO = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [9:0]    num_blocks = '0;
   logic          busy, frame_done, error_f;
   logic          in_valid = 1'b0;
   logic [511:0]  in_data = '0;
   logic          in_ready;
   logic [511:0]  dec_a;
   logic          dec_reset, dec_enable;
   logic [511:0]  dec_c;
   logic          dec_done;
   logic          out_valid;
   logic [511:0]  out_data;
   logic [9:0]    out_index;
   logic          out_ready = 1'b1;

   // Decoder stub state
   logic          stub_done = 1'b0;
   logic [511:0]  stub_c = '0;
   int            stub_cnt = 0;
   int            stub_lat = 2;
   logic          stub_hang = 1'b0;
   logic          stale_done = 1'b0;

   int checks = 0;
   int failures = 0;
   int fd_cnt = 0;
   int ir_cnt = 0;
   int rr_cnt = 0;
   logic rst_prev = 1'b1;
   int zz[64];

   typedef struct {
      logic [511:0] blk;
      int           lat;
      int           stall;
      logic [511:0] exp_d;
      int           exp_i;
   } vec_t;
   vec_t tab[4];

   always #5 clk = ~clk;

   decode_block_scheduler dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .num_blocks_i (num_blocks),
      .busy_o       (busy),
      .frame_done_o (frame_done),
      .error_o      (error_f),
      .in_valid_i   (in_valid),
      .in_data_i    (in_data),
      .in_ready_o   (in_ready),
      .dec_a_o      (dec_a),
      .dec_reset_o  (dec_reset),
      .dec_enable_o (dec_enable),
      .dec_c_i      (dec_c),
      .dec_done_i   (dec_done),
      .out_valid_o  (out_valid),
      .out_data_o   (out_data),
      .out_index_o  (out_index),
      .out_ready_i  (out_ready)
   );

   assign dec_c    = stub_c;
   assign dec_done = stub_done | stale_done;

   // Literal bytes (bit7=0) placed in zigzag order; bit7=1 codes a run of (bits6:0)+1 zeros.
   function automatic logic [511:0] ref_decode(input logic [511:0] a);
      logic [511:0] r;
      logic [7:0]   b;
      int           pos;
      r   = '0;
      pos = 0;
      for (int k = 0; k < 64; k++) begin
         if (pos < 64) begin
            b = a[k*8 +: 8];
            if (b[7]) begin
               pos = pos + int'(b[6:0]) + 1;
            end else begin
               r[zz[pos]*8 +: 8] = b;
               pos = pos + 1;
            end
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (dec_reset) begin
         stub_done <= 1'b0;
         stub_cnt  <= 0;
      end else if (dec_enable && !stub_done && !stub_hang) begin
         if (stub_cnt >= stub_lat) begin
            stub_done <= 1'b1;
            stub_c    <= ref_decode(dec_a);
         end else begin
            stub_cnt <= stub_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (in_ready) ir_cnt++;
      if (dec_reset && !rst_prev) rr_cnt++;
      rst_prev = dec_reset;
   end

   task automatic chk_b(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b, want %b", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic start_frame(input logic [9:0] n);
      start      = 1'b1;
      num_blocks = n;
      @(negedge clk);
      start = 1'b0;
      chk_b("start_busy", busy, 1'b1);
      chk_b("start_in_ready", in_ready, 1'b1);
   endtask

   // Returns at the negedge of the first RUN cycle.
   task automatic feed_block(input logic [511:0] blk);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk_b("in_ready_wait", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = blk;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      chk_b("clear_dec_reset", dec_reset, 1'b1);
      chk_b("clear_dec_enable", dec_enable, 1'b0);
      chk_w("dec_a_latched", dec_a, blk);
      @(negedge clk);
      chk_b("run_dec_reset", dec_reset, 1'b0);
      chk_b("run_dec_enable", dec_enable, 1'b1);
   endtask

   task automatic collect(input logic [511:0] exp_d, input int exp_i, input int stall);
      int n = 0;
      while (!out_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk_b("out_valid_wait", out_valid, 1'b1);
      if (stall > 0) begin
         out_ready = 1'b0;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk_b("stall_valid", out_valid, 1'b1);
            chk_w("stall_data", out_data, exp_d);
            chk_i("stall_index", int'(out_index), exp_i);
            chk_b("stall_in_ready", in_ready, 1'b0);
         end
         out_ready = 1'b1;
      end
      chk_w("out_data", out_data, exp_d);
      chk_i("out_index", int'(out_index), exp_i);
      @(negedge clk);
      chk_b("out_valid_drop", out_valid, 1'b0);
   endtask

   task automatic wait_frame_done();
      int n = 0;
      while (!frame_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_b("frame_done_seen", frame_done, 1'b1);
      chk_b("frame_done_busy", busy, 1'b0);
   endtask

   initial begin
      int n;
      n = 0;
      for (int s = 0; s < 15; s++) begin
         if (s % 2 == 0) begin
            for (int r = (s < 8 ? s : 7); r >= (s < 8 ? 0 : s - 7); r--) begin
               zz[n] = r * 8 + (s - r);
               n++;
            end
         end else begin
            for (int r = (s < 8 ? 0 : s - 7); r <= (s < 8 ? s : 7); r++) begin
               zz[n] = r * 8 + (s - r);
               n++;
            end
         end
      end

      tab[0] = '{blk: 512'hBF,       lat: 2, stall: 0,  exp_d: 512'h0,  exp_i: 0};
      tab[1] = '{blk: 512'hBE11,     lat: 5, stall: 10, exp_d: 512'h11, exp_i: 1};
      tab[2] = '{blk: 512'hBC030201, lat: 0, stall: 0,
                 exp_d: 512'h3_0000_0000_0000_0201, exp_i: 2};
      tab[3] = '{blk: {8'h80, {63{8'h05}}}, lat: 7, stall: 0,
                 exp_d: {8'h00, {63{8'h05}}}, exp_i: 0};

      // Reset values
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_b("rst_busy", busy, 1'b0);
      chk_b("rst_frame_done", frame_done, 1'b0);
      chk_b("rst_error", error_f, 1'b0);
      chk_b("rst_in_ready", in_ready, 1'b0);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_dec_reset", dec_reset, 1'b1);
      chk_b("rst_dec_enable", dec_enable, 1'b0);
      chk_w("rst_dec_a", dec_a, '0);
      chk_w("rst_out_data", out_data, '0);
      chk_i("rst_out_index", int'(out_index), 0);
      @(negedge clk);

      // Three-block frame; an extra start while busy must be ignored
      fd_cnt = 0;
      rr_cnt = 0;
      start_frame(10'd3);
      for (int i = 0; i < 3; i++) begin
         stub_lat = tab[i].lat;
         feed_block(tab[i].blk);
         if (i == 0) begin
            start      = 1'b1;
            num_blocks = 10'd7;
            @(negedge clk);
            start = 1'b0;
         end
         collect(tab[i].exp_d, tab[i].exp_i, tab[i].stall);
      end
      wait_frame_done();
      @(negedge clk);
      chk_i("frameA_done_count", fd_cnt, 1);
      chk_b("frameA_error", error_f, 1'b0);
      chk_i("frameA_clear_pulses", rr_cnt, 3);

      // Literal 0x05 block with trailing zero run
      repeat (2) @(negedge clk);
      rr_cnt = 0;
      fd_cnt = 0;
      start_frame(10'd1);
      stub_lat = tab[3].lat;
      feed_block(tab[3].blk);
      collect(tab[3].exp_d, tab[3].exp_i, tab[3].stall);
      wait_frame_done();
      @(negedge clk);
      chk_i("frameB_clear_pulses", rr_cnt, 1);
      chk_i("frameB_done_count", fd_cnt, 1);

      // Reset during RUN of block 1
      repeat (2) @(negedge clk);
      start_frame(10'd3);
      stub_lat = 2;
      feed_block(tab[0].blk);
      collect(tab[0].exp_d, 0, 0);
      stub_lat = 20;
      feed_block(tab[1].blk);
      reset = 1'b1;
      @(negedge clk);
      chk_b("midrst_busy", busy, 1'b0);
      chk_b("midrst_out_valid", out_valid, 1'b0);
      chk_b("midrst_in_ready", in_ready, 1'b0);
      chk_b("midrst_dec_reset", dec_reset, 1'b1);
      chk_b("midrst_dec_enable", dec_enable, 1'b0);
      chk_w("midrst_dec_a", dec_a, '0);
      chk_w("midrst_out_data", out_data, '0);
      chk_i("midrst_out_index", int'(out_index), 0);
      reset = 1'b0;
      @(negedge clk);

      // Clean single-block frame with a stale done in the first RUN cycle
      fd_cnt   = 0;
      stub_lat = 3;
      start_frame(10'd1);
      feed_block(tab[2].blk);
      stale_done = 1'b1;
      @(negedge clk);
      stale_done = 1'b0;
      chk_b("stale_done_masked", out_valid, 1'b0);
      collect(tab[2].exp_d, 0, 0);
      wait_frame_done();
      @(negedge clk);
      chk_i("post_rst_done_count", fd_cnt, 1);

      // Decoder hang -> watchdog abort
      repeat (2) @(negedge clk);
      fd_cnt    = 0;
      stub_hang = 1'b1;
      start_frame(10'd2);
      feed_block(tab[0].blk);
      repeat (TO - 1) @(negedge clk);
      chk_b("wdog_error_early", error_f, 1'b0);
      chk_b("wdog_busy_early", busy, 1'b1);
      @(negedge clk);
      chk_b("wdog_error", error_f, 1'b1);
      chk_b("wdog_dec_reset", dec_reset, 1'b1);
      chk_b("wdog_dec_enable", dec_enable, 1'b0);
      @(negedge clk);
      chk_b("abort_busy", busy, 1'b0);
      chk_b("abort_in_ready", in_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk_i("abort_no_frame_done", fd_cnt, 0);
      chk_b("abort_error_sticky", error_f, 1'b1);
      stub_hang = 1'b0;

      // Empty frame: clears error, frame_done two cycles after start, no fetch
      ir_cnt     = 0;
      start      = 1'b1;
      num_blocks = 10'd0;
      @(negedge clk);
      start = 1'b0;
      chk_b("empty_error_cleared", error_f, 1'b0);
      chk_b("empty_busy", busy, 1'b1);
      chk_b("empty_fd_early", frame_done, 1'b0);
      @(negedge clk);
      chk_b("empty_frame_done", frame_done, 1'b1);
      chk_b("empty_busy_drop", busy, 1'b0);
      @(negedge clk);
      chk_b("empty_fd_pulse", frame_done, 1'b0);
      repeat (2) @(negedge clk);
      chk_i("empty_no_in_ready", ir_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
